// File: rtl/ocw_frame_rx.sv
// Serial word-frame receiver: start/data/[parity]/stop deserializer with a 2-slot skid output buffer.
// Parity bit and PAR state are present only when OCW_FRAME_RX_PARITY_EN is defined.
module ocw_frame_rx #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin_vld,
  input  logic              sin_dat,
  output logic [WORD_W-1:0] word_o,
  output logic              word_vld_o,
  input  logic              word_rdy_i,
  output logic              par_err_o,
  output logic              frm_err_o,
  output logic              ovr_o,
  input  logic              ovr_clr_i,
  output logic              busy_o
);

`ifdef OCW_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   sreg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                push, pop, ferr_evt;
  logic                frm_err_q;
  logic [WORD_W-1:0]   slot0_q, slot1_q;
  logic [1:0]          occ_q;
  logic                ovr_q;

`ifdef OCW_FRAME_RX_PARITY_EN
  logic                perr_q, perr_evt, par_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    ferr_evt = 1'b0;
`ifdef OCW_FRAME_RX_PARITY_EN
    perr_evt = 1'b0;
`endif
    if (sin_vld) begin
      case (state_q)
        IDLE: if (!sin_dat) state_d = DATA;
        DATA: if (cnt_q == CNT_W'(WORD_W - 1)) begin
`ifdef OCW_FRAME_RX_PARITY_EN
          state_d = PAR;
`else
          state_d = STOP;
`endif
        end
`ifdef OCW_FRAME_RX_PARITY_EN
        PAR:  state_d = STOP;
`endif
        STOP: begin
          state_d = IDLE;
          // Framing error outranks parity error; only one pulse per frame.
          if (!sin_dat) ferr_evt = 1'b1;
`ifdef OCW_FRAME_RX_PARITY_EN
          else if (perr_q) perr_evt = 1'b1;
`endif
          else push = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
`ifdef OCW_FRAME_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else if (sin_vld) begin
      case (state_q)
        IDLE: if (!sin_dat) begin
          sreg_q <= '0;
          cnt_q  <= '0;
        end
        DATA: begin
          for (int unsigned i = 0; i < WORD_W; i++)
            if (cnt_q == CNT_W'(i)) sreg_q[i] <= sin_dat;
          if (cnt_q != CNT_W'(WORD_W - 1)) cnt_q <= cnt_q + CNT_W'(1);
        end
`ifdef OCW_FRAME_RX_PARITY_EN
        PAR:  perr_q <= sin_dat ^ (^sreg_q);
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_err_q <= 1'b0;
`ifdef OCW_FRAME_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      frm_err_q <= ferr_evt;
`ifdef OCW_FRAME_RX_PARITY_EN
      par_err_q <= perr_evt;
`endif
    end
  end

  assign pop = (occ_q != 2'd0) && word_rdy_i;

  // slot0 always drives word_o; slot1 only holds the second word when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
      ovr_q   <= 1'b0;
    end else begin
      case (occ_q)
        2'd0: if (push) begin
          slot0_q <= sreg_q;
          occ_q   <= 2'd1;
        end
        2'd1: begin
          if (push && pop) slot0_q <= sreg_q;
          else if (push) begin
            slot1_q <= sreg_q;
            occ_q   <= 2'd2;
          end else if (pop) occ_q <= 2'd0;
        end
        2'd2: if (pop) begin
          slot0_q <= slot1_q;
          if (push) slot1_q <= sreg_q;
          else      occ_q   <= 2'd1;
        end
        default: occ_q <= 2'd0;
      endcase
      if (push && (occ_q == 2'd2) && !pop) ovr_q <= 1'b1;
      else if (ovr_clr_i)                  ovr_q <= 1'b0;
    end
  end

  assign word_o     = slot0_q;
  assign word_vld_o = (occ_q != 2'd0);
  assign frm_err_o  = frm_err_q;
  assign ovr_o      = ovr_q;
  assign busy_o     = (state_q != IDLE);
`ifdef OCW_FRAME_RX_PARITY_EN
  assign par_err_o  = par_err_q;
`else
  assign par_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ocw_frame_rx.sv
// Directed self-checking bench for ocw_frame_rx; follows OCW_FRAME_RX_PARITY_EN for frame format.
module tb_ocw_frame_rx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin_vld, sin_dat;
  logic [15:0] word_o;
  logic        word_vld_o, word_rdy_i;
  logic        par_err_o, frm_err_o, ovr_o, ovr_clr_i, busy_o;
  int          checks = 0;
  int          errors = 0;

  ocw_frame_rx #(.WORD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sin_vld(sin_vld), .sin_dat(sin_dat),
    .word_o(word_o), .word_vld_o(word_vld_o), .word_rdy_i(word_rdy_i),
    .par_err_o(par_err_o), .frm_err_o(frm_err_o), .ovr_o(ovr_o),
    .ovr_clr_i(ovr_clr_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap);
    repeat (gap) tick();
    sin_vld = 1'b1;
    sin_dat = b;
    tick();
    sin_vld = 1'b0;
    sin_dat = 1'b1;
  endtask

  // Returns just after the edge that sampled the stop bit.
  task automatic send_frame(input logic [15:0] d, input logic par, input logic stop,
                            input int gap, input logic pop_on_stop);
    strobe(1'b0, gap);
    for (int i = 0; i < 16; i++) strobe(d[i], gap);
`ifdef OCW_FRAME_RX_PARITY_EN
    strobe(par, gap);
`endif
    repeat (gap) tick();
    word_rdy_i = pop_on_stop;
    strobe(stop, 0);
    word_rdy_i = 1'b0;
  endtask

  task automatic pop_one();
    word_rdy_i = 1'b1;
    tick();
    word_rdy_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sin_vld = 1'b0; sin_dat = 1'b1; word_rdy_i = 1'b0; ovr_clr_i = 1'b0;
    repeat (2) tick();
    checks++; if (word_o !== 16'h0000) begin errors++; $display("FAIL reset_word got %h exp 0000", word_o); end
    checks++; if ({word_vld_o, par_err_o, frm_err_o, ovr_o, busy_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {word_vld_o, par_err_o, frm_err_o, ovr_o, busy_o});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    send_frame(16'hA5C3, 1'b0, 1'b1, 0, 1'b0);
    checks++; if (word_vld_o !== 1'b1) begin errors++; $display("FAIL good_vld got %b exp 1", word_vld_o); end
    checks++; if (word_o !== 16'hA5C3) begin errors++; $display("FAIL good_word got %h exp a5c3", word_o); end
    checks++; if ({par_err_o, frm_err_o} !== 2'b00) begin errors++; $display("FAIL good_errs got %b exp 00", {par_err_o, frm_err_o}); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL good_busy got %b exp 0", busy_o); end
    pop_one();
    checks++; if (word_vld_o !== 1'b0) begin errors++; $display("FAIL good_pop got %b exp 0", word_vld_o); end
  endtask

  task automatic test_parity();
`ifdef OCW_FRAME_RX_PARITY_EN
    send_frame(16'hA5C3, 1'b1, 1'b1, 0, 1'b0);
    checks++; if (par_err_o !== 1'b1) begin errors++; $display("FAIL par_pulse got %b exp 1", par_err_o); end
    checks++; if (word_vld_o !== 1'b0) begin errors++; $display("FAIL par_drop got %b exp 0", word_vld_o); end
    tick();
    checks++; if (par_err_o !== 1'b0) begin errors++; $display("FAIL par_once got %b exp 0", par_err_o); end
`else
    send_frame(16'h5A3C, 1'b0, 1'b1, 0, 1'b0);
    checks++; if (par_err_o !== 1'b0) begin errors++; $display("FAIL par_tied got %b exp 0", par_err_o); end
    checks++; if (word_o !== 16'h5A3C) begin errors++; $display("FAIL nopar_word got %h exp 5a3c", word_o); end
    pop_one();
`endif
  endtask

  task automatic test_framing();
    send_frame(16'h0001, 1'b1, 1'b0, 0, 1'b0);
    checks++; if (frm_err_o !== 1'b1) begin errors++; $display("FAIL frm_pulse got %b exp 1", frm_err_o); end
    checks++; if (par_err_o !== 1'b0) begin errors++; $display("FAIL frm_par got %b exp 0", par_err_o); end
    checks++; if (word_vld_o !== 1'b0) begin errors++; $display("FAIL frm_drop got %b exp 0", word_vld_o); end
    tick();
    checks++; if (frm_err_o !== 1'b0) begin errors++; $display("FAIL frm_once got %b exp 0", frm_err_o); end
    send_frame(16'h1234, 1'b1, 1'b1, 0, 1'b0);
    checks++; if (word_o !== 16'h1234 || word_vld_o !== 1'b1) begin
      errors++; $display("FAIL frm_recover got %h/%b exp 1234/1", word_o, word_vld_o);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    send_frame(16'h0001, 1'b1, 1'b1, 0, 1'b0);
    send_frame(16'h0002, 1'b1, 1'b1, 0, 1'b0);
    checks++; if (ovr_o !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", ovr_o); end
    send_frame(16'h0003, 1'b0, 1'b1, 0, 1'b0);
    checks++; if (ovr_o !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", ovr_o); end
    checks++; if (word_o !== 16'h0001) begin errors++; $display("FAIL ovr_head got %h exp 0001", word_o); end
    pop_one();
    checks++; if (word_o !== 16'h0002 || word_vld_o !== 1'b1) begin
      errors++; $display("FAIL ovr_second got %h/%b exp 0002/1", word_o, word_vld_o);
    end
    pop_one();
    checks++; if (word_vld_o !== 1'b0) begin errors++; $display("FAIL ovr_empty got %b exp 0", word_vld_o); end
    checks++; if (ovr_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", ovr_o); end
    ovr_clr_i = 1'b1;
    tick();
    ovr_clr_i = 1'b0;
    checks++; if (ovr_o !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", ovr_o); end
  endtask

  task automatic test_back_to_back();
    send_frame(16'h1111, 1'b0, 1'b1, 2, 1'b0);
    send_frame(16'h2222, 1'b0, 1'b1, 2, 1'b1);
    checks++; if (word_o !== 16'h2222 || word_vld_o !== 1'b1) begin
      errors++; $display("FAIL b2b_first got %h/%b exp 2222/1", word_o, word_vld_o);
    end
    send_frame(16'h4321, 1'b1, 1'b1, 2, 1'b1);
    checks++; if (word_o !== 16'h4321 || word_vld_o !== 1'b1) begin
      errors++; $display("FAIL b2b_second got %h/%b exp 4321/1", word_o, word_vld_o);
    end
    pop_one();
    checks++; if (word_vld_o !== 1'b0) begin errors++; $display("FAIL b2b_occ got %b exp 0", word_vld_o); end
    checks++; if (ovr_o !== 1'b0) begin errors++; $display("FAIL b2b_ovr got %b exp 0", ovr_o); end
  endtask

  task automatic test_reset_mid();
    strobe(1'b0, 0);
    for (int i = 0; i < 7; i++) strobe(1'b1, 0);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy_o); end
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(16'hFFFF, 1'b0, 1'b1, 0, 1'b0);
    checks++; if (word_o !== 16'hFFFF || word_vld_o !== 1'b1) begin
      errors++; $display("FAIL mid_word got %h/%b exp ffff/1", word_o, word_vld_o);
    end
    pop_one();
    checks++; if (word_vld_o !== 1'b0) begin errors++; $display("FAIL mid_only got %b exp 0", word_vld_o); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_framing();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule

// File: doc/ocw_frame_rx.md
Name: ocw_frame_rx

Overview:
Receive-side endpoint for the serial word-frame link that carries 16-bit packed words of the [1:0][2:1][1:0][2:1] shape, with an XOR-parity bit per frame.
- Consumes a bit-strobed serial stream and deserializes each frame into one packed word.
- Checks framing and parity.
- Presents each accepted word on a valid/ready output with a one-word skid buffer.
- Sits between the link pins and the word-consumer logic in the same clock domain.

Parameters:
WORD_W, 16, data bits per frame; legal range 2..64.
CNT_W, $clog2(WORD_W+1), width of the internal bit counter; derived, do not override.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst_n  input  1  asynchronous assert, active-low reset; deassertion synchronised externally.
sin_vld  input  1  bit strobe; sin_dat is sampled only when high.
sin_dat  input  1  serial bit; frame is start(0), data LSB first, parity, stop(1).
word_o  output  WORD_W  received word, packed, bit 0 = first data bit.
word_vld_o  output  1  word_o holds an unconsumed word.
word_rdy_i  input  1  consumer accepts word_o when word_vld_o && word_rdy_i.
par_err_o  output  1  one-cycle pulse: parity mismatch, frame discarded.
frm_err_o  output  1  one-cycle pulse: stop bit was 0, frame discarded.
ovr_o  output  1  sticky: a good frame was dropped because both buffer slots were full.
ovr_clr_i  input  1  synchronous clear of ovr_o.
busy_o  output  1  FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, any time, mid-frame included) forces the following, with no partial word retained:
  - FSM to IDLE; shift register, bit counter and both buffer slots cleared.
  - word_o = 0, word_vld_o = 0, par_err_o = 0, frm_err_o = 0, ovr_o = 0, busy_o = 0.
- FSM advances only on cycles where sin_vld = 1; otherwise it holds.
  - IDLE: sin_dat = 0 goes to DATA with counter = 0. sin_dat = 1 stays in IDLE (line idle).
  - DATA: shift sin_dat into bit [counter], then counter += 1. At counter = WORD_W-1 the transition is to PAR.
  - PAR: compare sin_dat against the XOR-reduction of the WORD_W data bits (even parity over data plus parity bit). Store the mismatch flag and go to STOP.
  - STOP: the frame completes on this strobe and the FSM returns to IDLE. A new start bit is only recognised on a later strobe.
    - sin_dat = 0: frm_err_o pulses the next cycle and the word is dropped. Framing error takes priority over parity; only frm_err_o pulses.
    - sin_dat = 1 with the parity flag set: par_err_o pulses and the word is dropped.
    - sin_dat = 1 with no parity error: the word is pushed to the output buffer.
- Output buffer: 2 slots (head drives word_o, plus a skid slot).
  - Push latency: word_vld_o rises the cycle after the STOP strobe.
  - word_o is stable while word_vld_o && !word_rdy_i.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - A push while both slots are full drops the new word, sets ovr_o, and leaves the existing contents unchanged.
  - A pop with the buffer empty is ignored.
- ovr_o: set and clear in the same cycle resolves to set.
- busy_o = (state != IDLE), combinational from the state register.
- The counter never exceeds WORD_W-1; the bit index is width-checked, with no wrap.

Optional Feature:
OCW_FRAME_RX_PARITY_EN.
- Defined: the frame carries a parity bit and the PAR state exists, as described above.
- Undefined: the frame is start, data, stop. DATA goes directly to STOP, par_err_o is tied to 0, and no parity logic is synthesised.

Test Plan:
- Reset, then frame start, data 16'hA5C3 LSB first, parity 0, stop 1, with a strobe every cycle -> word_o = 16'hA5C3 and word_vld_o high the cycle after the stop strobe; par_err_o and frm_err_o stay 0.
- Same frame with the parity bit flipped to 1 -> par_err_o pulses once; word_vld_o stays 0.
- Data 16'h0001, parity 1, stop bit 0 -> frm_err_o pulses once, par_err_o stays 0, no word is delivered; the next valid frame of 16'h1234 is received correctly.
- word_rdy_i held 0 while three good frames 16'h0001, 16'h0002, 16'h0003 arrive -> ovr_o set after the third; the buffer pops 0001 then 0002 once rdy goes high; ovr_clr_i clears ovr_o.
- Strobes every 3rd cycle with a pop in the same cycle as a push -> no word is lost or duplicated; occupancy is constant.
- rst_n pulsed low after 7 data bits, then a full frame of 16'hFFFF with parity 0 -> only 16'hFFFF is delivered; busy_o is 0 during reset.
